deframer: RTL and testbench

// - Receive side of the byte framing protocol. Strips START_BYTE/STOP_BYTE delimiters from an
//   AXI4-Stream byte stream (e.g. a UART RX path) and outputs payload packets with tlast.
// - Sits between the byte-link receiver and packet consumers.
// - Payload must not contain START_BYTE or STOP_BYTE; no escaping is done.
//

---
 rtl/framing_pkg.sv | 13 +
 rtl/deframer.sv | 84 ++++++++
 tb/tb_deframer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/framing_pkg.sv
// Shared framing constants and deframer state encoding (also used by the framer).
package framing_pkg;

    localparam logic [7:0] DEF_START_BYTE = 8'h7D;
    localparam logic [7:0] DEF_STOP_BYTE  = 8'h7E;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        FIRST = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/deframer.sv
// Strips START/STOP delimiters from an AXI4-Stream byte stream and emits payload packets with tlast.
// Define DEFRAMER_ERR_EN to add initiator_tuser, flagging packets aborted by a repeated START.
module deframer
    import framing_pkg::*;
#(
    parameter logic [7:0] START_BYTE = DEF_START_BYTE,
    parameter logic [7:0] STOP_BYTE  = DEF_STOP_BYTE
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       target_tvalid,
    output logic       target_tready,
    input  logic [7:0] target_tdata,
    output logic       initiator_tvalid,
    input  logic       initiator_tready,
    output logic [7:0] initiator_tdata,
`ifdef DEFRAMER_ERR_EN
    output logic       initiator_tuser,
`endif
    output logic       initiator_tlast
);

    state_t     state;
    logic [7:0] hold;
    logic       accept;
    logic       is_start;
    logic       is_stop;

    // Only HOLD produces output, so only HOLD has to respect the output register.
    assign target_tready = !areset &&
                           ((state != HOLD) || !initiator_tvalid || initiator_tready);
    assign accept   = target_tvalid && target_tready;
    assign is_start = (target_tdata == START_BYTE);
    assign is_stop  = (target_tdata == STOP_BYTE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state            <= HUNT;
            hold             <= 8'h00;
            initiator_tvalid <= 1'b0;
            initiator_tdata  <= 8'h00;
            initiator_tlast  <= 1'b0;
`ifdef DEFRAMER_ERR_EN
            initiator_tuser  <= 1'b0;
`endif
        end else begin
            if (initiator_tready)
                initiator_tvalid <= 1'b0;
            if (accept) begin
                case (state)
                    HUNT: begin
                        if (is_start)
                            state <= FIRST;
                    end
                    FIRST: begin
                        if (is_stop) begin
                            state <= HUNT;
                        end else if (!is_start) begin
                            hold  <= target_tdata;
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        // The incoming byte decides whether the held byte ends the packet.
                        initiator_tvalid <= 1'b1;
                        initiator_tdata  <= hold;
                        initiator_tlast  <= is_stop || is_start;
`ifdef DEFRAMER_ERR_EN
                        initiator_tuser  <= is_start;
`endif
                        if (is_stop)
                            state <= HUNT;
                        else if (is_start)
                            state <= FIRST;
                        else
                            hold <= target_tdata;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deframer.sv
// Directed-vector scoreboard bench for deframer; expected beats are queued by stimulus, popped by a monitor.
module tb_deframer;

`ifdef DEFRAMER_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic       aclk;
    logic       areset;
    logic       target_tvalid;
    logic       target_tready;
    logic [7:0] target_tdata;
    logic       initiator_tvalid;
    logic       initiator_tready;
    logic [7:0] initiator_tdata;
    logic       initiator_tlast;
    logic       tuser_s;

    int    checks = 0;
    int    errors = 0;
    int    rmode  = 0;
    beat_t exp_q[$];

    deframer dut (
        .aclk             (aclk),
        .areset           (areset),
        .target_tvalid    (target_tvalid),
        .target_tready    (target_tready),
        .target_tdata     (target_tdata),
        .initiator_tvalid (initiator_tvalid),
        .initiator_tready (initiator_tready),
        .initiator_tdata  (initiator_tdata),
`ifdef DEFRAMER_ERR_EN
        .initiator_tuser  (tuser_s),
`endif
        .initiator_tlast  (initiator_tlast)
    );

`ifndef DEFRAMER_ERR_EN
    assign tuser_s = 1'b0;
`endif

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled.
    initial begin
        initiator_tready = 1'b1;
        forever begin
            @(negedge aclk);
            initiator_tready = (rmode == 0) ? 1'b1 :
                               (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: pops on each handshake, and checks output stability while stalled.
    initial begin
        bit    stalled;
        beat_t prev;
        beat_t cur;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge aclk);
            #4;
            if (areset) begin
                stalled = 1'b0;
            end else begin
                cur = '{d: initiator_tdata, l: initiator_tlast, u: tuser_s};
                if (stalled) begin
                    chk("stall_valid", 32'(initiator_tvalid), 32'd1);
                    chk("stall_beat", 32'(cur), 32'(prev));
                end
                if (initiator_tvalid && initiator_tready) begin
                    if (exp_q.size() == 0)
                        chk("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
                    else
                        chk("beat", 32'(cur), 32'(exp_q.pop_front()));
                end
                stalled = initiator_tvalid && !initiator_tready;
                prev    = cur;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        @(negedge aclk);
        target_tvalid = 1'b1;
        target_tdata  = b;
        while (!ok && n < 200) begin
            #4;
            ok = target_tready;
            @(posedge aclk);
            n++;
            if (!ok)
                @(negedge aclk);
        end
        #1;
        target_tvalid = 1'b0;
        if (!ok)
            chk("send_timeout", 32'(b), 32'hFFFF_FFFF);
    endtask

    task automatic send_seq(input logic [7:0] s[]);
        foreach (s[i])
            send(s[i]);
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l, input logic u);
        exp_q.push_back('{d: d, l: l, u: u});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge aclk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] big[];
        areset        = 1'b1;
        target_tvalid = 1'b0;
        target_tdata  = 8'h00;
        #1;
        chk("rst_tvalid", 32'(initiator_tvalid), 32'd0);
        chk("rst_tready", 32'(target_tready), 32'd0);
        chk("rst_tdata", 32'(initiator_tdata), 32'd0);
        chk("rst_tlast", 32'(initiator_tlast), 32'd0);
        chk("rst_tuser", 32'(tuser_s), 32'd0);
        repeat (2) @(negedge aclk);
        #2;
        areset = 1'b0;
        #1;
        chk("hunt_tready", 32'(target_tready), 32'd1);

        // Basic frame
        expect_beat(8'h01, 1'b0, 1'b0);
        expect_beat(8'h02, 1'b0, 1'b0);
        expect_beat(8'h03, 1'b1, 1'b0);
        send_seq('{8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E});
        drain("drain_basic");

        // Garbage before a frame is discarded
        expect_beat(8'h11, 1'b1, 1'b0);
        send_seq('{8'h55, 8'hAA, 8'h7E, 8'h7D, 8'h11, 8'h7E});
        drain("drain_garbage");

        // Empty frame dropped
        expect_beat(8'h22, 1'b1, 1'b0);
        send_seq('{8'h7D, 8'h7E, 8'h7D, 8'h22, 8'h7E});
        drain("drain_empty");

        // Repeated START aborts the open packet
        expect_beat(8'h01, 1'b0, 1'b0);
        expect_beat(8'h02, 1'b1, ERR);
        expect_beat(8'h03, 1'b1, 1'b0);
        send_seq('{8'h7D, 8'h01, 8'h02, 8'h7D, 8'h03, 8'h7E});
        drain("drain_abort");

        // 64-byte frame under random back-pressure
        rmode = 1;
        big = new[66];
        big[0] = 8'h7D;
        for (int i = 0; i < 64; i++) begin
            big[i + 1] = 8'(i + 1);
            expect_beat(8'(i + 1), (i == 63), 1'b0);
        end
        big[65] = 8'h7E;
        send_seq(big);
        drain("drain_long");
        rmode = 0;
        repeat (2) @(negedge aclk);

        // Reset mid-frame with an output beat pending
        rmode = 2;
        repeat (2) @(negedge aclk);
        send_seq('{8'h7D, 8'h01, 8'h02});
        @(negedge aclk);
        #2;
        chk("pend_tvalid", 32'(initiator_tvalid), 32'd1);
        chk("pend_tdata", 32'(initiator_tdata), 32'h01);
        areset = 1'b1;
        #1;
        chk("arst_tvalid", 32'(initiator_tvalid), 32'd0);
        chk("arst_tready", 32'(target_tready), 32'd0);
        @(negedge aclk);
        #2;
        areset = 1'b0;
        rmode  = 0;
        expect_beat(8'h09, 1'b1, 1'b0);
        send_seq('{8'h7D, 8'h09, 8'h7E});
        drain("drain_after_reset");

        repeat (5) @(negedge aclk);
        chk("idle_tvalid", 32'(initiator_tvalid), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
